// File: rtl/ads5296_delay_cal_if.sv
// Sample-mux and IDELAY control bus between the calibration sequencer and the capture lanes.
interface ads5296_delay_cal_if #(
  parameter int unsigned N_LANES = 33
);
  localparam int unsigned LANE_W = (N_LANES > 1) ? $clog2(N_LANES) : 1;

  logic [LANE_W-1:0]  lane_sel;
  logic [7:0]         sample_data;
  logic               sample_vld;
  logic [N_LANES-1:0] delay_load;
  logic [N_LANES-1:0] delay_en_vtc;
  logic [8:0]         delay_val;

  modport master (
    output lane_sel, delay_load, delay_en_vtc, delay_val,
    input  sample_data, sample_vld
  );

  modport slave (
    input  lane_sel, delay_load, delay_en_vtc, delay_val,
    output sample_data, sample_vld
  );
endinterface

// File: rtl/ads5296_delay_cal.sv
// IDELAY calibration sequencer: sweeps each lane's tap, finds the widest passing
// window against the ADC test pattern and loads its centre tap.
module ads5296_delay_cal #(
  parameter int unsigned N_LANES     = 33,
  parameter int unsigned MAX_TAP     = 511,
  parameter int unsigned TAP_STEP    = 8,
  parameter int unsigned SETTLE_CYC  = 16,
  parameter int unsigned CMP_CNT     = 64,
  parameter logic [7:0]  PATTERN     = 8'hF0,
  parameter int unsigned MIN_WIN     = 4,
  parameter int unsigned DEFAULT_TAP = 256,
  localparam int unsigned LANE_W     = (N_LANES > 1) ? $clog2(N_LANES) : 1
) (
  input  logic                     user_clk,
  input  logic                     user_rst,
  input  logic                     start,
  input  logic                     abort,
  ads5296_delay_cal_if.master      cal_bus,
  output logic                     busy,
  output logic                     done,
  output logic [N_LANES-1:0]       fail_mask,
  input  logic [LANE_W-1:0]        rd_lane,
  output logic [8:0]               rd_tap
);

  localparam int unsigned TAP_W   = 9;
  localparam int unsigned SUM_W   = 10;
  localparam int unsigned LEN_W   = 10;
  localparam int unsigned NXT_W   = 11;
  localparam int unsigned CNT_MAX = (SETTLE_CYC > CMP_CNT) ? SETTLE_CYC : CMP_CNT;
  localparam int unsigned CNT_W   = $clog2(CNT_MAX + 1);

  localparam logic [3:0] S_IDLE    = 4'd0;
  localparam logic [3:0] S_PREP    = 4'd1;
  localparam logic [3:0] S_LOAD    = 4'd2;
  localparam logic [3:0] S_SETTLE  = 4'd3;
  localparam logic [3:0] S_CHECK   = 4'd4;
  localparam logic [3:0] S_EVAL    = 4'd5;
  localparam logic [3:0] S_FINAL   = 4'd6;
  localparam logic [3:0] S_FSETTLE = 4'd7;
  localparam logic [3:0] S_NEXT    = 4'd8;

  logic [3:0]         state_q, state_d;
  logic [LANE_W-1:0]  lane_q, lane_d;
  logic [TAP_W-1:0]   tap_q, tap_d;
  logic [CNT_W-1:0]   cnt_q, cnt_d;
  logic               err_q, err_d;
  logic [LEN_W-1:0]   run_len_q, run_len_d;
  logic [TAP_W-1:0]   run_start_q, run_start_d;
  logic [TAP_W-1:0]   run_end_q, run_end_d;
  logic [LEN_W-1:0]   best_len_q, best_len_d;
  logic [TAP_W-1:0]   best_start_q, best_start_d;
  logic [TAP_W-1:0]   best_end_q, best_end_d;
  logic               abort_q, abort_d;
  logic               force_fail_q, force_fail_d;
  logic               busy_q, busy_d;
  logic               done_q, done_d;
  logic [N_LANES-1:0] fail_mask_q, fail_mask_d;
  logic [N_LANES-1:0] load_q, load_d;
  logic [N_LANES-1:0] en_vtc_q, en_vtc_d;
  logic [TAP_W-1:0]   val_q, val_d;
  logic [TAP_W-1:0]   tap_tab_q [N_LANES];
  logic [TAP_W-1:0]   tap_tab_d [N_LANES];
  logic [TAP_W-1:0]   rd_tap_q, rd_tap_d;

  logic               abort_now_c;
  logic [NXT_W-1:0]   tap_nxt_c;
  logic [SUM_W-1:0]   fin_sum_c;
  logic [TAP_W-1:0]   fin_tap_c;
  logic [N_LANES-1:0] lane_onehot_c;

  // Next-state and datapath decisions
  always_comb begin
    state_d      = state_q;
    lane_d       = lane_q;
    tap_d        = tap_q;
    cnt_d        = cnt_q;
    err_d        = err_q;
    run_len_d    = run_len_q;
    run_start_d  = run_start_q;
    run_end_d    = run_end_q;
    best_len_d   = best_len_q;
    best_start_d = best_start_q;
    best_end_d   = best_end_q;
    abort_d      = abort_q;
    force_fail_d = force_fail_q;
    busy_d       = busy_q;
    done_d       = 1'b0;
    fail_mask_d  = fail_mask_q;
    load_d       = '0;
    en_vtc_d     = en_vtc_q;
    val_d        = val_q;
    tap_tab_d    = tap_tab_q;

    abort_now_c   = abort_q | abort;
    tap_nxt_c     = NXT_W'(tap_q) + NXT_W'(TAP_STEP);
    fin_sum_c     = SUM_W'(best_start_q) + SUM_W'(best_end_q);
    fin_tap_c     = TAP_W'(DEFAULT_TAP);
    lane_onehot_c = N_LANES'(1) << lane_q;

    if (state_q != S_IDLE && abort) abort_d = 1'b1;

    case (state_q)
      S_IDLE: begin
        if (start) begin
          busy_d      = 1'b1;
          lane_d      = '0;
          fail_mask_d = '0;
          abort_d     = 1'b0;
          state_d     = S_PREP;
        end
      end
      S_PREP: begin
        en_vtc_d     = ~lane_onehot_c;
        tap_d        = '0;
        run_len_d    = '0;
        best_len_d   = '0;
        force_fail_d = 1'b0;
        if (abort_now_c) begin
          force_fail_d = 1'b1;
          state_d      = S_FINAL;
        end else begin
          state_d = S_LOAD;
        end
      end
      S_LOAD: begin
        val_d   = tap_q;
        load_d  = lane_onehot_c;
        cnt_d   = '0;
        err_d   = 1'b0;
        state_d = S_SETTLE;
      end
      S_SETTLE: begin
        if (cnt_q == CNT_W'(SETTLE_CYC - 1)) begin
          cnt_d   = '0;
          state_d = S_CHECK;
        end else begin
          cnt_d = cnt_q + CNT_W'(1);
        end
      end
      S_CHECK: begin
        // Only qualified samples advance the count or can flag an error
        if (cal_bus.sample_vld) begin
          if (cal_bus.sample_data != PATTERN) err_d = 1'b1;
          if (cnt_q == CNT_W'(CMP_CNT - 1)) state_d = S_EVAL;
          else                              cnt_d   = cnt_q + CNT_W'(1);
        end
      end
      S_EVAL: begin
        if (!err_q) begin
          if (run_len_q == '0) run_start_d = tap_q;
          run_len_d = run_len_q + LEN_W'(1);
          run_end_d = tap_q;
        end else begin
          run_len_d = '0;
        end
        // Strict compare keeps the earliest window on a tie
        if (run_len_d > best_len_q) begin
          best_len_d   = run_len_d;
          best_start_d = run_start_d;
          best_end_d   = run_end_d;
        end
        if (tap_nxt_c <= NXT_W'(MAX_TAP)) begin
          tap_d = TAP_W'(tap_nxt_c);
          if (abort_now_c) begin
            force_fail_d = 1'b1;
            state_d      = S_FINAL;
          end else begin
            state_d = S_LOAD;
          end
        end else begin
          state_d = S_FINAL;
        end
      end
      S_FINAL: begin
        if (!force_fail_q && best_len_q >= LEN_W'(MIN_WIN)) begin
          fin_tap_c = TAP_W'(fin_sum_c >> 1);
        end else begin
          fail_mask_d[lane_q] = 1'b1;
        end
        tap_d             = fin_tap_c;
        val_d             = fin_tap_c;
        load_d            = lane_onehot_c;
        tap_tab_d[lane_q] = fin_tap_c;
        cnt_d             = '0;
        state_d           = S_FSETTLE;
      end
      S_FSETTLE: begin
        if (cnt_q == CNT_W'(SETTLE_CYC - 1)) begin
          en_vtc_d = '1;
          state_d  = S_NEXT;
        end else begin
          cnt_d = cnt_q + CNT_W'(1);
        end
      end
      S_NEXT: begin
        if (abort_now_c || lane_q == LANE_W'(N_LANES - 1)) begin
          busy_d  = 1'b0;
          done_d  = 1'b1;
          abort_d = 1'b0;
          state_d = S_IDLE;
        end else begin
          lane_d  = lane_q + LANE_W'(1);
          state_d = S_PREP;
        end
      end
      default: state_d = S_IDLE;
    endcase

    rd_tap_d = (32'(rd_lane) < N_LANES) ? tap_tab_q[rd_lane] : TAP_W'(DEFAULT_TAP);
  end

  // State and output registers
  always_ff @(posedge user_clk) begin
    if (user_rst) begin
      state_q      <= S_IDLE;
      lane_q       <= '0;
      tap_q        <= '0;
      cnt_q        <= '0;
      err_q        <= 1'b0;
      run_len_q    <= '0;
      run_start_q  <= '0;
      run_end_q    <= '0;
      best_len_q   <= '0;
      best_start_q <= '0;
      best_end_q   <= '0;
      abort_q      <= 1'b0;
      force_fail_q <= 1'b0;
      busy_q       <= 1'b0;
      done_q       <= 1'b0;
      fail_mask_q  <= '0;
      load_q       <= '0;
      en_vtc_q     <= '1;
      val_q        <= '0;
      rd_tap_q     <= TAP_W'(DEFAULT_TAP);
      for (int i = 0; i < int'(N_LANES); i++) tap_tab_q[i] <= TAP_W'(DEFAULT_TAP);
    end else begin
      state_q      <= state_d;
      lane_q       <= lane_d;
      tap_q        <= tap_d;
      cnt_q        <= cnt_d;
      err_q        <= err_d;
      run_len_q    <= run_len_d;
      run_start_q  <= run_start_d;
      run_end_q    <= run_end_d;
      best_len_q   <= best_len_d;
      best_start_q <= best_start_d;
      best_end_q   <= best_end_d;
      abort_q      <= abort_d;
      force_fail_q <= force_fail_d;
      busy_q       <= busy_d;
      done_q       <= done_d;
      fail_mask_q  <= fail_mask_d;
      load_q       <= load_d;
      en_vtc_q     <= en_vtc_d;
      val_q        <= val_d;
      rd_tap_q     <= rd_tap_d;
      tap_tab_q    <= tap_tab_d;
    end
  end

  assign cal_bus.lane_sel     = lane_q;
  assign cal_bus.delay_load   = load_q;
  assign cal_bus.delay_en_vtc = en_vtc_q;
  assign cal_bus.delay_val    = val_q;
  assign busy                 = busy_q;
  assign done                 = done_q;
  assign fail_mask            = fail_mask_q;
  assign rd_tap               = rd_tap_q;

endmodule

// File: doc/ads5296_delay_cal.md
Name: ads5296_delay_cal

Overview:
- Automatic IDELAY calibration sequencer for the ADS5296x4 capture interface.
- Processes one lane at a time, sweeping the delay tap across its range.
- At each tap it checks the captured lane word against the ADC test pattern, finds the widest passing window and loads the centre tap.
- Sits in the user_clk domain beside the wishbone attach block; its delay_load/delay_en_vtc/delay_val outputs are OR/muxed with the software-driven controls before reaching the IDELAYs.

Parameters:
- N_LANES, 33, number of delay-controlled lanes (data lanes + fclk); max 64.
- MAX_TAP, 511, last tap value swept (≤ 511).
- TAP_STEP, 8, tap increment per sweep point (≥ 1).
- SETTLE_CYC, 16, user_clk cycles to wait after a load before sampling (≥ 1).
- CMP_CNT, 64, valid samples compared per tap (≥ 1).
- PATTERN, 8'hF0, expected captured word.
- MIN_WIN, 4, minimum passing sweep points for a lane to be declared good.
- DEFAULT_TAP, 256, tap loaded on a failed lane.

Ports:
- user_clk  in  1  Clock.
- user_rst  in  1  Synchronous active-high reset.
- start  in  1  Single-cycle pulse; begins calibration of all lanes. Ignored while busy.
- abort  in  1  Single-cycle pulse; ends the run at the next state boundary.
- lane_sel  out  $clog2(N_LANES)  Lane currently under test; drives the external sample mux.
- sample_data  in  8  Muxed captured word for lane_sel.
- sample_vld  in  1  sample_data qualifier.
- delay_load  out  N_LANES  One-hot load strobe.
- delay_en_vtc  out  N_LANES  Per-lane EN_VTC.
- delay_val  out  9  Tap value presented with delay_load.
- busy  out  1  Calibration in progress.
- done  out  1  One-cycle pulse at the end of a run (normal or abort).
- fail_mask  out  N_LANES  Bit set = lane had no window ≥ MIN_WIN.
- rd_lane  in  $clog2(N_LANES)  Result readback index.
- rd_tap  out  9  Final tap for rd_lane (registered, 1-cycle latency).

Behaviour:
- Reset values:
  - state IDLE; busy = 0, done = 0.
  - delay_load = 0, delay_en_vtc = all 1, delay_val = 0, lane_sel = 0.
  - fail_mask = 0, tap table = DEFAULT_TAP, rd_tap = DEFAULT_TAP.
  - Reset mid-run abandons the run immediately; no done pulse.
- States and transitions:
  - IDLE:
    - On start: busy = 1, lane = 0, clear fail_mask.
    - Go to PREP.
  - PREP:
    - delay_en_vtc[lane] = 0.
    - Clear tap = 0, run_len = 0, best_len = 0.
    - Wait 1 cycle, then go to LOAD.
  - LOAD:
    - delay_val = tap, delay_load[lane] = 1 for exactly 1 cycle.
    - Go to SETTLE.
  - SETTLE:
    - Count SETTLE_CYC cycles, then go to CHECK.
  - CHECK:
    - Count CMP_CNT cycles with sample_vld = 1; cycles without sample_vld are not counted.
    - err sets on any valid sample ≠ PATTERN.
    - When the count completes, go to EVAL.
  - EVAL, pass (err = 0):
    - If run_len == 0, run_start = tap.
    - run_len++, run_end = tap.
  - EVAL, fail: run_len = 0.
  - EVAL, window update:
    - If run_len > best_len (strict, so the first-found window wins ties): best_start = run_start, best_end = run_end, best_len = run_len.
    - If tap + TAP_STEP ≤ MAX_TAP: tap += TAP_STEP, go to LOAD.
    - Otherwise go to FINAL.
  - FINAL:
    - If best_len ≥ MIN_WIN: tap = (best_start + best_end) >> 1, with the sum computed on 10 bits.
    - Otherwise: tap = DEFAULT_TAP and fail_mask[lane] = 1.
    - Write tap to the table, pulse delay_load with the final tap, wait SETTLE_CYC.
    - Set delay_en_vtc[lane] = 1, go to NEXT.
  - NEXT:
    - If lane == N_LANES−1: go to IDLE, pulse done, busy = 0.
    - Otherwise: lane++, go to PREP.
- Window boundaries:
  - The tap sweep never exceeds MAX_TAP; the last point is the largest multiple of TAP_STEP ≤ MAX_TAP.
  - A window that runs to the last point is valid; there is no wrap-around between the last and first taps.
- Abort:
  - Sampled in any busy state and latched.
  - Acted on at the next LOAD or NEXT entry.
  - The current lane gets DEFAULT_TAP loaded with its fail bit set, and its EN_VTC is restored.
  - Untested lanes are left unchanged.
  - Then: done pulse, IDLE.
- Simultaneous start and abort in IDLE: start is taken and the abort is ignored.
- Output invariants:
  - At most one delay_load bit and at most one delay_en_vtc = 0 bit at any time.
  - delay_load is asserted only while delay_en_vtc[lane] = 0.

Test Plan:
- N_LANES = 2, MAX_TAP = 15, TAP_STEP = 1, SETTLE_CYC = 2, CMP_CNT = 4, MIN_WIN = 4.
  - Stimulus: model passes taps 3–10 on lane 0 and taps 0–15 on lane 1; start.
  - Response: rd_tap(0) = 6, rd_tap(1) = 7, fail_mask = 0, exactly one done pulse, 34 delay_load pulses.
- Lane 0 with two windows, 2–5 and 9–12 (equal length).
  - Response: first window is chosen, rd_tap(0) = 3.
- Lane 0 passes only at taps 7–8 (below MIN_WIN).
  - Response: fail_mask[0] = 1, rd_tap(0) = DEFAULT_TAP, final delay_val = DEFAULT_TAP.
- Hold sample_vld low for 10 cycles in CHECK, with wrong data present while vld is low.
  - Response: the FSM stalls and the taps are still judged as passing.
- Abort during lane 0 tap 5.
  - Response: lane 0 is loaded with DEFAULT_TAP and fail_mask = 01; lane 1 is untouched; done pulses once; all EN_VTC bits are 1.
- Assert user_rst mid-SETTLE.
  - Response: next cycle busy = 0, delay_load = 0, en_vtc all 1, no done pulse; a subsequent start completes normally.
